pps_status_monitor: RTL and testbench
=====================================

// Module: pps_status_monitor
// PURPOSE
// - Parametrised successor to the top-level status/LED glue. Aggregates NUM_ERR maskable error sources into sticky
//   flags plus a saturating event count, and filters sync lock.
// - Derives cam_ready and the 4-bit status_code, and drives one status LED from a prioritised blink-mode FSM.
// - Sits in the top level between parser/extractor/CI/PPS status outputs and the board pins.
// PARAMETERS
// - NUM_ERR      4   number of error inputs
// - LOCK_FILTER  16  consecutive locked cycles required before sync_locked rises (>=1)
// - PRESCALE_W   24  blink prescaler width
// - FAST_BIT     20  prescaler bit used for error blink (< SLOW_BIT)
// - SLOW_BIT     22  prescaler bit used for no-sync blink (< PRESCALE_W-1)
// PORTS
// - clk          in   1        system clock
// - rst_n        in   1        async active-low reset
// - err_in       in   NUM_ERR  level error sources
// - err_mask     in   NUM_ERR  1 = ignore source
// - err_clear    in   1        pulse: clear sticky flags and err_count
// - t2mi_lock    in   1        parser sync lock
// - pps_lock     in   1        PPS generator sync status
// - cam_present  in   1        CAM detected
// - cam_init     in   1        CAM initialised
// - cam_bypass   in   1        CAM bypass selected
// - autonomous   in   1        PPS autonomous (holdover) mode
// - sync_locked  out  1        filtered lock
// - cam_ready    out  1        registered cam_present & cam_init
// - system_error out  1        OR of err_sticky
// - err_sticky   out  NUM_ERR  per-source sticky flags
// - err_count    out  8        saturating count of error onsets
// - status_code  out  4        {cam_ready, sync_locked, autonomous_r, system_error}
// - led_mode     out  2        current LED FSM state
// - led          out  1        status LED
// BEHAVIOUR
// - Reset:
//   - All outputs 0, led_mode=OK.
//   - Prescaler, lock counter, err_count and previous-error register cleared.
// - Lock filter:
//   - raw = t2mi_lock & pps_lock.
//   - lock_cnt increments while raw=1, saturating at LOCK_FILTER; any raw=0 clears it.
//   - sync_locked is registered = (lock_cnt==LOCK_FILTER), so it rises LOCK_FILTER+1 cycles after raw rises.
//   - It falls 1 cycle after raw falls (fast drop, no hysteresis on loss).
// - Errors:
//   - em = err_in & ~err_mask.
//   - err_sticky[i] <= em[i] | (err_sticky[i] & ~err_clear); set wins over a simultaneous clear.
//   - system_error = |err_sticky, comb from regs, i.e. 1 cycle after em.
//   - onset = |em & ~|em_prev; err_count increments on onset, saturating at 255.
//   - err_clear zeroes err_count; if onset coincides with the clear, err_count becomes 1.
//   - Masking an already-set sticky bit does not clear it.
// - cam_ready and autonomous_r are registered (1-cycle latency); status_code is comb from registered signals.
// - LED FSM: priority ERR > NOSYNC > NOCAM > OK, evaluated every cycle from the registered flags.
//   - ERR when system_error; NOSYNC when !sync_locked; NOCAM when !cam_bypass & !cam_ready; else OK.
//   - On any led_mode change the prescaler restarts at 0; otherwise it free-runs and wraps.
//   - led output (registered): OK=1; ERR=presc[FAST_BIT]; NOSYNC=presc[SLOW_BIT]; NOCAM=presc[PRESCALE_W-1].
//   - So each new blink pattern starts with an OFF phase; the first ON edge of ERR follows 2^FAST_BIT cycles after entry.
// - Async reset mid-operation returns everything to reset state immediately; no state survives.
// STRUCTURE
// - Package t2mi_status_pkg holds the LED mode encodings (OK=0, ERR=1, NOSYNC=2, NOCAM=3) and the status_code bit indices.
// - One sub-module, status_lock_filter (param LOCK_FILTER; in clk, rst_n, raw; out locked), is instantiated once.
// - Error, LED FSM and prescaler logic stay inline.
// TESTING (sim params: LOCK_FILTER=4, PRESCALE_W=8, FAST_BIT=2, SLOW_BIT=4, NUM_ERR=4)
// - Reset, all inputs 0 -> all outputs 0, led_mode=NOSYNC from the first clock, led=0 for 16 cycles then toggles every 16.
// - t2mi_lock=pps_lock=1 at cycle 0 -> sync_locked=1 at cycle 5.
//   - Drop pps_lock for 1 cycle -> sync_locked=0 next cycle, and it re-rises 5 cycles after restore.
// - err_in=4'b0010 pulse of 1 cycle -> err_sticky=0010, system_error=1 and err_count=1 next cycle, led_mode=ERR.
//   - Two further separated pulses -> err_count=3.
//   - Held error for 10 cycles -> count increments once.
// - err_clear coincident with err_in=0001 -> err_sticky=0001 and err_count=1.
//   - err_clear alone afterwards -> err_sticky=0, err_count=0, system_error=0.
// - err_mask=4'b1111, err_in=4'b1111 -> err_sticky stays 0.
//   - 300 unmasked onsets -> err_count saturates at 255.
// - Locked, cam_present=1, cam_init=0, cam_bypass=0 -> led_mode=NOCAM, led=0 for 128 cycles then 1.
//   - Set cam_bypass=1 -> led_mode=OK, led=1, status_code=4'b0100.
//   - Assert rst_n=0 mid-run -> outputs 0 the same cycle.

Source files
------------

// File: rtl/pps_status_monitor_pkg.sv
// Purpose : shared LED mode encodings, status_code bit positions and error-count limit.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package t2mi_status_pkg;

  // Status LED blink modes; the encoding is visible on the led_mode pins.
  typedef enum logic [1:0] {
    LED_OK     = 2'd0,
    LED_ERR    = 2'd1,
    LED_NOSYNC = 2'd2,
    LED_NOCAM  = 2'd3
  } led_mode_e;

  // Bit positions inside status_code = {cam_ready, sync_locked, autonomous_r, system_error}.
  localparam int SC_SYS_ERR = 0;
  localparam int SC_AUTO    = 1;
  localparam int SC_SYNC    = 2;
  localparam int SC_CAM     = 3;

  localparam logic [7:0] ERR_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/pps_status_monitor_if.sv
// Purpose : bundles the status inputs and board-facing status outputs of the monitor.
// Latency : n/a (wires only).
// Backpressure: none; all signals are levels or single-cycle pulses.
// master = status sources / board side, slave = pps_status_monitor.
interface pps_status_if #(
  parameter int NUM_ERR = 4
);
  logic [NUM_ERR-1:0] err_in;
  logic [NUM_ERR-1:0] err_mask;
  logic               err_clear;
  logic               t2mi_lock;
  logic               pps_lock;
  logic               cam_present;
  logic               cam_init;
  logic               cam_bypass;
  logic               autonomous;

  logic               sync_locked;
  logic               cam_ready;
  logic               system_error;
  logic [NUM_ERR-1:0] err_sticky;
  logic [7:0]         err_count;
  logic [3:0]         status_code;
  logic [1:0]         led_mode;
  logic               led;

  modport master (
    output err_in, err_mask, err_clear, t2mi_lock, pps_lock,
           cam_present, cam_init, cam_bypass, autonomous,
    input  sync_locked, cam_ready, system_error, err_sticky,
           err_count, status_code, led_mode, led
  );

  modport slave (
    input  err_in, err_mask, err_clear, t2mi_lock, pps_lock,
           cam_present, cam_init, cam_bypass, autonomous,
    output sync_locked, cam_ready, system_error, err_sticky,
           err_count, status_code, led_mode, led
  );
endinterface

// File: rtl/pps_status_monitor_lock_filter.sv
// Purpose : debounces a raw lock level; locked rises only after LOCK_FILTER consecutive raw cycles.
// Latency : rise LOCK_FILTER+1 cycles after raw rises, fall 1 cycle after raw drops.
// Backpressure: none.
// Ports: clk, rst_n (async active-low), raw (lock level in), locked (filtered lock out).
module status_lock_filter #(
  parameter int LOCK_FILTER = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic locked
);
  localparam int CW = (LOCK_FILTER < 1) ? 1 : $clog2(LOCK_FILTER + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_FILTER);

  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          locked_q, locked_d;

  always_comb begin
    lock_cnt_d = '0;
    if (raw) begin
      lock_cnt_d = (lock_cnt_q == CNT_MAX) ? lock_cnt_q : lock_cnt_q + 1'b1;
    end
    // Gating with raw gives the fast drop on loss: one low cycle is enough.
    locked_d = raw && (lock_cnt_q == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked = locked_q;
endmodule

// File: rtl/pps_status_monitor.sv
// Purpose : aggregates maskable error sources, filters sync lock and drives status code + blinking LED.
// Latency : all outputs registered or comb from registers; 1 cycle from inputs (lock: LOCK_FILTER+1).
// Backpressure: none; inputs are sampled every cycle.
// Ports: clk, rst_n (async active-low), bus (pps_status_if.slave: error/lock/CAM inputs,
//        sync_locked/cam_ready/system_error/err_sticky/err_count/status_code/led_mode/led outputs).
module pps_status_monitor
  import t2mi_status_pkg::*;
#(
  parameter int NUM_ERR     = 4,
  parameter int LOCK_FILTER = 16,
  parameter int PRESCALE_W  = 24,
  parameter int FAST_BIT    = 20,
  parameter int SLOW_BIT    = 22
) (
  input logic         clk,
  input logic         rst_n,
  pps_status_if.slave bus
);

  // ---------------- lock filter ----------------
  logic sync_locked;

  status_lock_filter #(
    .LOCK_FILTER(LOCK_FILTER)
  ) u_lock_filter (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (bus.t2mi_lock & bus.pps_lock),
    .locked(sync_locked)
  );

  // ---------------- errors ----------------
  logic [NUM_ERR-1:0] em;
  logic [NUM_ERR-1:0] em_prev_q, em_prev_d;
  logic [NUM_ERR-1:0] err_sticky_q, err_sticky_d;
  logic [7:0]         err_count_q, err_count_d;
  logic               onset;
  logic               system_error;

  assign em           = bus.err_in & ~bus.err_mask;
  // Onset is a transition of the aggregate, so a held error counts once.
  assign onset        = (|em) & ~(|em_prev_q);
  assign system_error = |err_sticky_q;

  always_comb begin
    em_prev_d    = em;
    // A new error in the clear cycle survives the clear.
    err_sticky_d = em | (err_sticky_q & ~{NUM_ERR{bus.err_clear}});
    err_count_d  = err_count_q;
    if (bus.err_clear) begin
      err_count_d = onset ? 8'd1 : 8'd0;
    end else if (onset && (err_count_q != ERR_COUNT_MAX)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  // ---------------- CAM / autonomous flags ----------------
  logic cam_ready_q, cam_ready_d;
  logic autonomous_q, autonomous_d;

  always_comb begin
    cam_ready_d  = bus.cam_present & bus.cam_init;
    autonomous_d = bus.autonomous;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em_prev_q    <= '0;
      err_sticky_q <= '0;
      err_count_q  <= '0;
      cam_ready_q  <= 1'b0;
      autonomous_q <= 1'b0;
    end else begin
      em_prev_q    <= em_prev_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      cam_ready_q  <= cam_ready_d;
      autonomous_q <= autonomous_d;
    end
  end

  // ---------------- LED FSM ----------------
  led_mode_e              led_mode_q, led_mode_d;
  logic [PRESCALE_W-1:0]  presc_q, presc_d;
  logic                   led_q, led_d;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_mode_q <= LED_OK;
    end else begin
      led_mode_q <= led_mode_d;
    end
  end

  // Next state: fixed priority ERR > NOSYNC > NOCAM > OK.
  always_comb begin
    led_mode_d = LED_OK;
    if (system_error) begin
      led_mode_d = LED_ERR;
    end else if (!sync_locked) begin
      led_mode_d = LED_NOSYNC;
    end else if (!bus.cam_bypass && !cam_ready_q) begin
      led_mode_d = LED_NOCAM;
    end
  end

  // Outputs: prescaler restarts on every mode change so each pattern opens
  // with its OFF phase; led is derived from the next mode/prescaler so it
  // lines up with the registered led_mode.
  always_comb begin
    presc_d = (led_mode_d != led_mode_q) ? '0 : presc_q + 1'b1;
    led_d   = 1'b1;
    case (led_mode_d)
      LED_OK:     led_d = 1'b1;
      LED_ERR:    led_d = presc_d[FAST_BIT];
      LED_NOSYNC: led_d = presc_d[SLOW_BIT];
      LED_NOCAM:  led_d = presc_d[PRESCALE_W-1];
      default:    led_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      led_q   <= 1'b0;
    end else begin
      presc_q <= presc_d;
      led_q   <= led_d;
    end
  end

  // ---------------- output mapping ----------------
  logic [3:0] status_code;

  always_comb begin
    status_code             = 4'd0;
    status_code[SC_CAM]     = cam_ready_q;
    status_code[SC_SYNC]    = sync_locked;
    status_code[SC_AUTO]    = autonomous_q;
    status_code[SC_SYS_ERR] = system_error;
  end

  assign bus.sync_locked  = sync_locked;
  assign bus.cam_ready    = cam_ready_q;
  assign bus.system_error = system_error;
  assign bus.err_sticky   = err_sticky_q;
  assign bus.err_count    = err_count_q;
  assign bus.status_code  = status_code;
  assign bus.led_mode     = led_mode_q;
  assign bus.led          = led_q;

endmodule

// File: tb/tb_pps_status_monitor.sv
// Directed bench for pps_status_monitor with small prescaler/filter parameters.
module tb_pps_status_monitor;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pps_status_if #(.NUM_ERR(4)) bus ();

  pps_status_monitor #(
    .NUM_ERR    (4),
    .LOCK_FILTER(4),
    .PRESCALE_W (8),
    .FAST_BIT   (2),
    .SLOW_BIT   (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n           = 1'b0;
    bus.err_in      = 4'd0;
    bus.err_mask    = 4'd0;
    bus.err_clear   = 1'b0;
    bus.t2mi_lock   = 1'b0;
    bus.pps_lock    = 1'b0;
    bus.cam_present = 1'b0;
    bus.cam_init    = 1'b0;
    bus.cam_bypass  = 1'b0;
    bus.autonomous  = 1'b0;

    // Reset state
    tick(2);
    chk("rst_sync_locked", 32'(bus.sync_locked), 32'd0);
    chk("rst_cam_ready", 32'(bus.cam_ready), 32'd0);
    chk("rst_system_error", 32'(bus.system_error), 32'd0);
    chk("rst_err_sticky", 32'(bus.err_sticky), 32'd0);
    chk("rst_err_count", 32'(bus.err_count), 32'd0);
    chk("rst_status_code", 32'(bus.status_code), 32'd0);
    chk("rst_led_mode", 32'(bus.led_mode), 32'd0);
    chk("rst_led", 32'(bus.led), 32'd0);
    rst_n = 1'b1;

    // NOSYNC blink: led low for 16 cycles then toggles every 16
    tick(1);
    chk("nosync_mode", 32'(bus.led_mode), 32'd2);
    chk("nosync_led_c1", 32'(bus.led), 32'd0);
    tick(15);
    chk("nosync_led_c16", 32'(bus.led), 32'd0);
    tick(1);
    chk("nosync_led_c17", 32'(bus.led), 32'd1);
    tick(15);
    chk("nosync_led_c32", 32'(bus.led), 32'd1);
    tick(1);
    chk("nosync_led_c33", 32'(bus.led), 32'd0);

    // Lock filter: rises 5 cycles after raw lock
    bus.t2mi_lock = 1'b1;
    bus.pps_lock  = 1'b1;
    tick(4);
    chk("lock_c4", 32'(bus.sync_locked), 32'd0);
    tick(1);
    chk("lock_c5", 32'(bus.sync_locked), 32'd1);
    chk("lock_status_code", 32'(bus.status_code), 32'b0100);
    bus.pps_lock = 1'b0;
    tick(1);
    chk("lock_drop", 32'(bus.sync_locked), 32'd0);
    bus.pps_lock = 1'b1;
    tick(4);
    chk("relock_c4", 32'(bus.sync_locked), 32'd0);
    tick(1);
    chk("relock_c5", 32'(bus.sync_locked), 32'd1);

    // Single error pulse
    bus.err_in = 4'b0010;
    tick(1);
    bus.err_in = 4'b0000;
    chk("pulse_sticky", 32'(bus.err_sticky), 32'b0010);
    chk("pulse_syserr", 32'(bus.system_error), 32'd1);
    chk("pulse_count", 32'(bus.err_count), 32'd1);
    tick(1);
    chk("pulse_led_mode", 32'(bus.led_mode), 32'd1);
    chk("pulse_sticky_hold", 32'(bus.err_sticky), 32'b0010);

    // Two further separated pulses
    for (int p = 0; p < 2; p++) begin
      bus.err_in = 4'b0010;
      tick(1);
      bus.err_in = 4'b0000;
      tick(1);
    end
    chk("pulses_count3", 32'(bus.err_count), 32'd3);

    // Held error counts once
    bus.err_in = 4'b0100;
    tick(10);
    bus.err_in = 4'b0000;
    tick(1);
    chk("held_count4", 32'(bus.err_count), 32'd4);
    chk("held_sticky", 32'(bus.err_sticky), 32'b0110);

    // Clear coincident with new onset
    bus.err_clear = 1'b1;
    bus.err_in    = 4'b0001;
    tick(1);
    chk("clr_onset_sticky", 32'(bus.err_sticky), 32'b0001);
    chk("clr_onset_count", 32'(bus.err_count), 32'd1);
    bus.err_in    = 4'b0000;
    bus.err_clear = 1'b0;
    tick(1);
    bus.err_clear = 1'b1;
    tick(1);
    bus.err_clear = 1'b0;
    chk("clr_sticky", 32'(bus.err_sticky), 32'd0);
    chk("clr_count", 32'(bus.err_count), 32'd0);
    chk("clr_syserr", 32'(bus.system_error), 32'd0);

    // Fully masked errors
    bus.err_mask = 4'b1111;
    bus.err_in   = 4'b1111;
    tick(3);
    chk("mask_sticky", 32'(bus.err_sticky), 32'd0);
    chk("mask_count", 32'(bus.err_count), 32'd0);
    bus.err_in   = 4'b0000;
    bus.err_mask = 4'b0000;
    tick(1);

    // Saturation
    for (int p = 0; p < 300; p++) begin
      bus.err_in = 4'b0001;
      tick(1);
      bus.err_in = 4'b0000;
      tick(1);
    end
    chk("sat_count", 32'(bus.err_count), 32'd255);

    // Masking a set sticky bit keeps it
    bus.err_mask = 4'b0001;
    tick(1);
    chk("mask_keeps_sticky", 32'(bus.err_sticky), 32'b0001);
    bus.err_mask = 4'b0000;

    // NOCAM blink: clear errors with lock held and CAM not ready
    bus.cam_present = 1'b1;
    bus.cam_init    = 1'b0;
    bus.cam_bypass  = 1'b0;
    bus.err_clear   = 1'b1;
    tick(1);
    bus.err_clear   = 1'b0;
    chk("nocam_clr_syserr", 32'(bus.system_error), 32'd0);
    tick(1);
    chk("nocam_mode", 32'(bus.led_mode), 32'd3);
    chk("nocam_led_c1", 32'(bus.led), 32'd0);
    tick(127);
    chk("nocam_led_c128", 32'(bus.led), 32'd0);
    tick(1);
    chk("nocam_led_c129", 32'(bus.led), 32'd1);

    // Bypass -> OK
    bus.cam_bypass = 1'b1;
    tick(1);
    chk("ok_mode", 32'(bus.led_mode), 32'd0);
    chk("ok_led", 32'(bus.led), 32'd1);
    chk("ok_status_code", 32'(bus.status_code), 32'b0100);
    bus.autonomous = 1'b1;
    bus.cam_init   = 1'b1;
    tick(1);
    chk("auto_cam_status_code", 32'(bus.status_code), 32'b1110);

    // Async reset mid-run
    bus.err_in = 4'b1000;
    tick(1);
    bus.err_in = 4'b0000;
    chk("pre_rst_sticky", 32'(bus.err_sticky), 32'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sticky", 32'(bus.err_sticky), 32'd0);
    chk("arst_count", 32'(bus.err_count), 32'd0);
    chk("arst_status_code", 32'(bus.status_code), 32'd0);
    chk("arst_led_mode", 32'(bus.led_mode), 32'd0);
    chk("arst_led", 32'(bus.led), 32'd0);
    chk("arst_cam_ready", 32'(bus.cam_ready), 32'd0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_sync", 32'(bus.sync_locked), 32'd0);
    chk("post_rst_mode", 32'(bus.led_mode), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
